// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/EXEC/MEM control sequencer with valid/ready opcode intake.
// Optional CTRL_STALL_EN adds a stall input that freezes EXEC/MEM and blocks FETCH acceptance.
module control_fsm #(
  parameter int OPWIDTH   = 3,
  parameter int MCODEBITS = 3,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [MCODEBITS-1:0] instruction,
  input  logic                 alu_zero,
`ifdef CTRL_STALL_EN
  input  logic                 stall,
`endif
  output logic                 branch,
  output logic                 memToReg,
  output logic                 memWrite,
  output logic                 aluSrc,
  output logic                 regWrite,
  output logic [OPWIDTH-1:0]   aluOp,
  output logic                 retire,
  output logic                 illegal
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, MEM = 2'd3;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  logic [1:0]           state_q, state_d;
  logic [MCODEBITS-1:0] op_q, op_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 stl, run, legal, is_mem, last, in_ex, in_mem;
  logic [2:0]           op3;
`ifdef CTRL_STALL_EN
  assign stl = stall;
`else
  assign stl = 1'b0;
`endif
  assign run    = !stl;
  assign op3    = op_q[2:0];
  assign legal  = (op_q >> 3) == '0;
  assign is_mem = legal && (op3 == 3'd5 || op3 == 3'd6);
  assign last   = cnt_q == '0;
  assign in_ex  = state_q == EXEC;
  assign in_mem = state_q == MEM;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (instr_valid && instr_ready) begin
        op_d    = instruction;
        state_d = EXEC;
      end
      EXEC: if (run) begin
        state_d = is_mem ? MEM : FETCH;
        cnt_d   = is_mem ? CW'(MEM_LAT - 1) : cnt_q;
      end
      default: if (run) begin
        state_d = last ? FETCH : MEM;
        cnt_d   = last ? cnt_q : cnt_q - CW'(1);
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
  // Strobes are gated by run so a stalled cycle never fires them; aluOp/aluSrc hold.
  assign instr_ready = state_q == FETCH && !stl;
  assign aluOp    = ((in_ex || in_mem) && legal && op3 != 3'd7) ? OPWIDTH'(op3) : '1;
  assign aluSrc   = (in_ex || in_mem) && legal && op3 != 3'd0 && op3 != 3'd7;
  assign branch   = run && in_ex && legal && ((op3 == 3'd1 && alu_zero) || op3 == 3'd7);
  assign memToReg = run && in_mem && op3 == 3'd5;
  assign memWrite = run && in_mem && op3 == 3'd6 && cnt_q == CW'(MEM_LAT - 1);
  assign regWrite = run && ((in_ex && legal && (op3 == 3'd0 || op3 == 3'd2 || op3 == 3'd3 || op3 == 3'd4))
                            || (in_mem && op3 == 3'd5 && last));
  assign retire   = run && ((in_ex && !is_mem) || (in_mem && last));
  assign illegal  = run && in_ex && !legal;
endmodule
